// File: rtl/transizione_livello_arbitro.sv
// rtl/transizione_livello_arbitro.sv - toggle-handshake receiver with round-robin grant
//
// Purpose: N_CANALI producers each announce an item by toggling rdy_in[i]. Pending
// channels are granted one at a time to a single consumer in round-robin order.
// Each accepted item is answered by toggling ack_out[i].
//
// Ports:
//   clock    in   1         posedge clock
//   reset    in   1         asynchronous, active-high
//   rdy_in   in   N_CANALI  producer ready lines (level-transition encoded)
//   beta     in   1         consumer accepts the granted channel (used only while valido)
//   ack_out  out  N_CANALI  producer ack lines (level-transition encoded, registered)
//   pronto   out  N_CANALI  channel pending: synchronised rdy XOR last acked level
//   valido   out  1         grant active (registered)
//   indice   out  IDX_W     granted channel, stable while valido (registered)
//   errore   out  1         sticky protocol error (second toggle before ack)

module transizione_livello_arbitro #(
  parameter int N_CANALI   = 4,
  parameter int SYNC_STADI = 1,
  parameter int IDX_W      = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_CANALI-1:0] rdy_in,
  input  logic                beta,
  output logic [N_CANALI-1:0] ack_out,
  output logic [N_CANALI-1:0] pronto,
  output logic                valido,
  output logic [IDX_W-1:0]    indice,
  output logic                errore
);

  typedef enum logic {IDLE, GRANT} stato_t;

  stato_t              stato, stato_next;
  logic [N_CANALI-1:0] s_d;       // value s will take at the next edge
  logic [N_CANALI-1:0] s_q;       // last synchroniser stage
  logic [N_CANALI-1:0] c_q;       // last acknowledged level per channel
  logic [IDX_W-1:0]    ptr;       // round-robin start point
  logic [IDX_W-1:0]    scelta;    // first pending channel from ptr onwards
  logic [IDX_W-1:0]    ptr_succ;  // (indice + 1) mod N_CANALI
  logic                ack_fire;
  int                  rr_sum;
  int                  succ_sum;

  // Synchroniser: SYNC_STADI registers in total, the last one being s_q.
  generate
    if (SYNC_STADI == 1) begin : g_no_pre
      assign s_d = rdy_in;
    end else begin : g_pre
      logic [N_CANALI-1:0] pre_q [SYNC_STADI-1];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < SYNC_STADI - 1; k++) pre_q[k] <= '0;
        end else begin
          pre_q[0] <= rdy_in;
          for (int k = 1; k < SYNC_STADI - 1; k++) pre_q[k] <= pre_q[k-1];
        end
      end
      assign s_d = pre_q[SYNC_STADI-2];
    end
  endgenerate

  assign pronto  = s_q ^ c_q;
  assign ack_out = c_q;
  assign valido  = (stato == GRANT);

  // Round-robin pick: first pending channel scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    scelta = '0;
    rr_sum = 0;
    for (int k = N_CANALI - 1; k >= 0; k--) begin
      // Scanning backwards lets the lowest offset win without a found flag.
      rr_sum = int'(ptr) + k;
      if (rr_sum >= N_CANALI) rr_sum = rr_sum - N_CANALI;
      if (pronto[IDX_W'(rr_sum)]) scelta = IDX_W'(rr_sum);
    end
  end

  always_comb begin
    succ_sum = int'(indice) + 1;
    if (succ_sum >= N_CANALI) succ_sum = 0;
    ptr_succ = IDX_W'(succ_sum);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stato <= IDLE;
    else       stato <= stato_next;
  end

  always_comb begin
    stato_next = stato;
    ack_fire   = 1'b0;
    case (stato)
      IDLE: begin
        if (|pronto) stato_next = GRANT;
      end
      GRANT: begin
        // A producer that cancelled its request (double toggle) loses the grant
        // without an ack; the pointer stays so nobody is skipped.
        if (!pronto[indice]) begin
          stato_next = IDLE;
        end else if (beta) begin
          ack_fire   = 1'b1;
          stato_next = IDLE;
        end
      end
      default: stato_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      c_q    <= '0;
      ptr    <= '0;
      indice <= '0;
      errore <= 1'b0;
    end else begin
      s_q <= s_d;
      if (stato == IDLE && |pronto) indice <= scelta;
      if (ack_fire) begin
        c_q[indice] <= ~c_q[indice];
        ptr         <= ptr_succ;
      end
      if (|((s_d ^ s_q) & pronto)) errore <= 1'b1;
    end
  end

endmodule
